// File: rtl/capture_seg.sv
// capture_seg: segmented capture controller for the logic-analyzer RAM path.
//
// The RAM is split into SEGS circular segments of SEG_DEPTH entries. A run
// captures up to num_segs+1 triggered acquisitions, one per segment. Each
// segment holds SEG_DEPTH-1-trig_pos pre-trigger samples, one trigger sample
// and trig_pos post-trigger samples.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wrt_smpl          sample strobe
//   run               run mode from cmd_cfg
//   capture_done      capture_done bit from cmd_cfg (released by the host)
//   triggered         level trigger from the trigger unit
//   trig_pos          post-trigger samples per segment (latched at run start)
//   num_segs          segments minus 1 (latched at run start)
//   we, waddr         RAM write enable / address
//   set_capture_done  pulse with the final write of the last segment
//   armed             pre-trigger fill complete
//   trig_clr          asks the trigger unit to drop triggered between segments
//   trig_wr           pulse with the trigger-sample write
//   trig_seg          segment index of that trigger sample
//   trig_addr         RAM address of that trigger sample
module capture_seg #(
  parameter int ENTRIES  = 384,
  parameter int LOG2     = 9,
  parameter int SEGS     = 4,
  parameter int SEG_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wrt_smpl,
  input  logic                run,
  input  logic                capture_done,
  input  logic                triggered,
  input  logic [LOG2-1:0]     trig_pos,
  input  logic [SEG_LOG2-1:0] num_segs,
  output logic                we,
  output logic [LOG2-1:0]     waddr,
  output logic                set_capture_done,
  output logic                armed,
  output logic                trig_clr,
  output logic                trig_wr,
  output logic [SEG_LOG2-1:0] trig_seg,
  output logic [LOG2-1:0]     trig_addr
);

  localparam int SEG_DEPTH = ENTRIES / SEGS;
  localparam logic [LOG2-1:0] SD_M1 = LOG2'(SEG_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, REARM, DONE} state_t;

  state_t              state;
  logic [SEG_LOG2-1:0] seg_idx, num_segs_l;
  logic [LOG2-1:0]     offset, pre_cnt, post_cnt, tp_l;
  logic [LOG2-1:0]     tp_in, pre_in, pre_n, offset_nxt;
  logic                hit, seg_end, last_seg;

  // Clamp so a segment always keeps at least the trigger sample.
  assign tp_in  = (trig_pos > SD_M1) ? SD_M1 : trig_pos;
  assign pre_in = SD_M1 - tp_in;   // pre-trigger count for the run being started
  assign pre_n  = SD_M1 - tp_l;    // pre-trigger count for the latched run

  assign offset_nxt = (offset == SD_M1) ? '0 : offset + 1'b1;

  // Dropping run kills writes in the same cycle.
  assign we       = (state inside {PRE, ARMED, POST}) && run && wrt_smpl;
  assign waddr    = LOG2'(seg_idx) * LOG2'(SEG_DEPTH) + offset;
  assign armed    = (state == ARMED);
  assign trig_clr = (state == REARM);

  assign hit      = (state == ARMED) && we && triggered;
  assign last_seg = (seg_idx == num_segs_l);
  assign seg_end  = (hit && tp_l == '0) ||
                    ((state == POST) && we && (post_cnt == tp_l - 1'b1));

  assign trig_wr          = hit;
  assign trig_seg         = hit ? seg_idx : '0;
  assign trig_addr        = hit ? waddr : '0;
  assign set_capture_done = seg_end && last_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      seg_idx    <= '0;
      num_segs_l <= '0;
      offset     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      tp_l       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            offset     <= '0;
            seg_idx    <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            tp_l       <= tp_in;
            num_segs_l <= num_segs;
            state      <= (pre_in == '0) ? ARMED : PRE;
          end
        end

        PRE, ARMED, POST: begin
          if (!run) begin
            state <= IDLE;
          end else if (wrt_smpl) begin
            offset <= offset_nxt;
            case (state)
              PRE: begin
                pre_cnt <= pre_cnt + 1'b1;
                if (pre_cnt == pre_n - 1'b1) state <= ARMED;
              end
              ARMED: begin
                if (triggered) begin
                  post_cnt <= '0;
                  if (tp_l != '0) state <= POST;
                end
              end
              default: post_cnt <= post_cnt + 1'b1;  // POST
            endcase
            // Segment end overrides the per-state updates above.
            if (seg_end) begin
              if (last_seg) begin
                state <= DONE;
              end else begin
                seg_idx <= seg_idx + 1'b1;
                offset  <= '0;
                pre_cnt <= '0;
                state   <= REARM;
              end
            end
          end
        end

        REARM: begin
          // Hold until the previous trigger is gone so one event can't
          // retrigger the next segment.
          if (!run)            state <= IDLE;
          else if (!triggered) state <= (pre_n == '0) ? ARMED : PRE;
        end

        DONE: begin
          if (!capture_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_seg.sv
// Directed testbench for capture_seg (ENTRIES=384, SEGS=4, SEG_DEPTH=96).
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_capture_seg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wrt_smpl, run, capture_done, triggered;
  logic [8:0] trig_pos;
  logic [1:0] num_segs;
  logic       we, set_capture_done, armed, trig_clr, trig_wr;
  logic [8:0] waddr, trig_addr;
  logic [1:0] trig_seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  capture_seg #(.ENTRIES(384), .LOG2(9), .SEGS(4), .SEG_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .run(run),
    .capture_done(capture_done), .triggered(triggered), .trig_pos(trig_pos),
    .num_segs(num_segs), .we(we), .waddr(waddr),
    .set_capture_done(set_capture_done), .armed(armed), .trig_clr(trig_clr),
    .trig_wr(trig_wr), .trig_seg(trig_seg), .trig_addr(trig_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // e_addr < 0 skips the address check
  task automatic expw(input string tag, input logic e_we, input int e_addr,
                      input logic e_arm, input logic e_tw, input logic e_scd);
    chk({tag, " we"}, 32'(we), 32'(e_we));
    if (e_addr >= 0) chk({tag, " waddr"}, 32'(waddr), 32'(e_addr));
    chk({tag, " armed"}, 32'(armed), 32'(e_arm));
    chk({tag, " trig_wr"}, 32'(trig_wr), 32'(e_tw));
    chk({tag, " scd"}, 32'(set_capture_done), 32'(e_scd));
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic to_idle();
    cyc();
    run = 1'b0;
    capture_done = 1'b0;
    #1;
    chk("to_idle we", 32'(we), 32'd0);
  endtask

  // PRE==0 cases: arm right after run, trigger at offset 2, 95 post writes.
  task automatic run_tp(input logic [8:0] tp, input string tag);
    cyc();
    num_segs = 2'd0; trig_pos = tp; run = 1'b1; wrt_smpl = 1'b1; triggered = 1'b0;
    #1;
    expw({tag, " idle"}, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 97; k++) begin
      cyc();
      triggered = (k >= 2);
      if (k >= 1) begin
        trig_pos = 9'd0;     // must be ignored mid-run
        num_segs = 2'd3;
      end
      #1;
      expw(tag, 1'b1, k % 96, k <= 2, k == 2, k == 97);
      if (k == 2) chk({tag, " trig_addr"}, 32'(trig_addr), 32'd2);
    end
    cyc();
    capture_done = 1'b1;
    #1;
    chk({tag, " done we"}, 32'(we), 32'd0);
    to_idle();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; wrt_smpl = 1'b0; run = 1'b0; capture_done = 1'b0;
    triggered = 1'b0; trig_pos = '0; num_segs = '0;
    #2;
    chk("rst we", 32'(we), 32'd0);
    chk("rst waddr", 32'(waddr), 32'd0);
    chk("rst armed", 32'(armed), 32'd0);
    chk("rst trig_clr", 32'(trig_clr), 32'd0);
    chk("rst trig_wr", 32'(trig_wr), 32'd0);
    chk("rst scd", 32'(set_capture_done), 32'd0);
    cyc();
    rst_n = 1'b1;

    // 1: single shot, trig_pos=10, PRE=85, trigger on write 90
    cyc();
    num_segs = 2'd0; trig_pos = 9'd10; run = 1'b1; wrt_smpl = 1'b1;
    #1;
    expw("t1 idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 100; k++) begin
      cyc();
      triggered = (k >= 90);
      #1;
      expw("t1", 1'b1, k % 96, k >= 85 && k <= 90, k == 90, k == 100);
      if (k == 90) begin
        chk("t1 trig_addr", 32'(trig_addr), 32'd90);
        chk("t1 trig_seg", 32'(trig_seg), 32'd0);
      end
    end

    // 6a: DONE holds while capture_done=1, then leaves via IDLE
    for (int i = 0; i < 20; i++) begin
      cyc();
      capture_done = 1'b1;
      #1;
      expw("t6 done", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    end
    cyc();
    capture_done = 1'b0;
    #1;
    chk("t6 last done we", 32'(we), 32'd0);
    cyc();
    #1;
    chk("t6 idle we", 32'(we), 32'd0);
    cyc();
    #1;
    expw("t6 restart", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    to_idle();

    // 2: four segments, trig_pos=0, trigger held across segment ends
    cyc();
    num_segs = 2'd3; trig_pos = 9'd0; run = 1'b1; wrt_smpl = 1'b1; triggered = 1'b1;
    #1;
    expw("t2 idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 96; k++) begin
        cyc();
        triggered = 1'b1;
        #1;
        expw("t2", 1'b1, s * 96 + k, k == 95, k == 95, k == 95 && s == 3);
        chk("t2 trig_clr", 32'(trig_clr), 32'd0);
        if (k == 95) chk("t2 trig_seg", 32'(trig_seg), 32'(s));
      end
      if (s < 3) begin
        for (int r = 0; r < 3; r++) begin
          cyc();
          #1;
          chk("t2 rearm clr", 32'(trig_clr), 32'd1);
          chk("t2 rearm we", 32'(we), 32'd0);
        end
        cyc();
        triggered = 1'b0;
        #1;
        chk("t2 drop clr", 32'(trig_clr), 32'd1);
        chk("t2 drop we", 32'(we), 32'd0);
      end
    end
    cyc();
    capture_done = 1'b1;
    #1;
    expw("t2 done", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    to_idle();

    // 3: PRE=0, and an out-of-range trig_pos clamps to the same behaviour
    run_tp(9'd95, "t3 tp95");
    run_tp(9'd200, "t3 tp200");

    // 4: strobe every 3rd cycle, PRE=5, trigger raised off-strobe
    cyc();
    num_segs = 2'd0; trig_pos = 9'd90; run = 1'b1; wrt_smpl = 1'b0; triggered = 1'b0;
    #1;
    expw("t4 idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i <= 294; i++) begin
      cyc();
      wrt_smpl = (i % 3 == 0);
      triggered = (i >= 22);
      #1;
      expw("t4", wrt_smpl, n % 96, n >= 5 && n <= 8, i == 24, n == 98 && wrt_smpl);
      if (i == 24) chk("t4 trig_addr", 32'(trig_addr), 32'd8);
      if (wrt_smpl) n++;
    end
    cyc();
    wrt_smpl = 1'b1;
    capture_done = 1'b1;
    #1;
    chk("t4 done we", 32'(we), 32'd0);
    to_idle();

    // 5a: run dropped in POST
    cyc();
    num_segs = 2'd1; trig_pos = 9'd10; run = 1'b1; wrt_smpl = 1'b1; triggered = 1'b0;
    #1;
    expw("t5 idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 90; k++) begin
      cyc();
      triggered = (k >= 85);
      #1;
      expw("t5a", 1'b1, k, k == 85, k == 85, 1'b0);
    end
    cyc();
    run = 1'b0;
    #1;
    expw("t5 drop post", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    cyc();
    run = 1'b1;
    #1;
    expw("t5 post->idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    // 5b: rerun from seg 0, reach REARM, drop run there
    for (int k = 0; k < 96; k++) begin
      cyc();
      triggered = (k >= 85);
      #1;
      expw("t5b", 1'b1, k, k == 85, k == 85, 1'b0);
    end
    cyc();
    #1;
    chk("t5 rearm clr", 32'(trig_clr), 32'd1);
    chk("t5 rearm we", 32'(we), 32'd0);
    cyc();
    run = 1'b0;
    #1;
    chk("t5 drop rearm clr", 32'(trig_clr), 32'd1);
    chk("t5 drop rearm we", 32'(we), 32'd0);
    cyc();
    run = 1'b1;
    #1;
    chk("t5 rearm->idle clr", 32'(trig_clr), 32'd0);
    expw("t5 rearm->idle", 1'b0, -1, 1'b0, 1'b0, 1'b0);
    cyc();
    #1;
    expw("t5 rerun", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    to_idle();

    // 6b: asynchronous reset mid-POST
    cyc();
    num_segs = 2'd0; trig_pos = 9'd10; run = 1'b1; wrt_smpl = 1'b1; triggered = 1'b0;
    for (int k = 0; k <= 88; k++) begin
      cyc();
      triggered = (k >= 85);
      #1;
    end
    expw("t6 post", 1'b1, 88, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 arst we", 32'(we), 32'd0);
    chk("t6 arst waddr", 32'(waddr), 32'd0);
    chk("t6 arst armed", 32'(armed), 32'd0);
    chk("t6 arst trig_clr", 32'(trig_clr), 32'd0);
    chk("t6 arst trig_wr", 32'(trig_wr), 32'd0);
    chk("t6 arst trig_seg", 32'(trig_seg), 32'd0);
    chk("t6 arst trig_addr", 32'(trig_addr), 32'd0);
    chk("t6 arst scd", 32'(set_capture_done), 32'd0);
    cyc();
    run = 1'b0;
    rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
